// File: rtl/numeric_attr_parser_pkg.sv
// numeric_attr_parser_pkg
// Shared definitions for the numeric attribute parser:
//   - CHAR_BITS     : default character code width
//   - C_*           : character code constants (hash, percent, terminators, digit/letter ranges)
//   - state_t       : parser state encoding
package numeric_attr_parser_pkg;

  localparam int unsigned CHAR_BITS = 8;

  localparam logic [7:0] C_HASH   = 8'h23;  // '#'
  localparam logic [7:0] C_PCT    = 8'h25;  // '%'
  localparam logic [7:0] C_SPACE  = 8'h20;  // ' '
  localparam logic [7:0] C_GT     = 8'h3E;  // '>'
  localparam logic [7:0] C_DQUOTE = 8'h22;  // '"'
  localparam logic [7:0] C_SQUOTE = 8'h27;  // '\''
  localparam logic [7:0] C_SLASH  = 8'h2F;  // '/'
  localparam logic [7:0] C_0      = 8'h30;
  localparam logic [7:0] C_9      = 8'h39;
  localparam logic [7:0] C_LA     = 8'h61;
  localparam logic [7:0] C_LF     = 8'h66;
  localparam logic [7:0] C_UA     = 8'h41;
  localparam logic [7:0] C_UF     = 8'h46;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_DIGITS = 3'd2,
    S_SUFFIX = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

endpackage

// File: rtl/numeric_attr_parser_char_digit_decoder.sv
// char_digit_decoder
// Combinational character classifier for the numeric attribute parser.
// Ports:
//   i_char       : character code
//   i_hex        : 1 = hexadecimal digits also accepted
//   o_is_digit   : character is a digit in the current base
//   o_digit      : digit value (valid when o_is_digit)
//   o_is_term    : character is an attribute terminator
//   o_is_hash    : character is '#'
//   o_is_percent : character is '%'
module char_digit_decoder
  import numeric_attr_parser_pkg::*;
#(
  parameter int unsigned CHAR_WIDTH = CHAR_BITS
) (
  input  logic [CHAR_WIDTH-1:0] i_char,
  input  logic                  i_hex,
  output logic                  o_is_digit,
  output logic [3:0]            o_digit,
  output logic                  o_is_term,
  output logic                  o_is_hash,
  output logic                  o_is_percent
);

  logic w_dec;
  logic w_alpha;

  always_comb begin
    w_dec   = (i_char >= CHAR_WIDTH'(C_0)) && (i_char <= CHAR_WIDTH'(C_9));
    w_alpha = i_hex &&
              (((i_char >= CHAR_WIDTH'(C_LA)) && (i_char <= CHAR_WIDTH'(C_LF))) ||
               ((i_char >= CHAR_WIDTH'(C_UA)) && (i_char <= CHAR_WIDTH'(C_UF))));
    o_is_digit = w_dec || w_alpha;
    // '0'-'9' carry their value in the low nibble; 'a'-'f'/'A'-'F' have low nibble 1-6
    o_digit = w_alpha ? (i_char[3:0] + 4'd9) : i_char[3:0];
    o_is_term = (i_char == CHAR_WIDTH'(C_SPACE))  || (i_char == CHAR_WIDTH'(C_GT))     ||
                (i_char == CHAR_WIDTH'(C_DQUOTE)) || (i_char == CHAR_WIDTH'(C_SQUOTE)) ||
                (i_char == CHAR_WIDTH'(C_SLASH));
    o_is_hash    = (i_char == CHAR_WIDTH'(C_HASH));
    o_is_percent = (i_char == CHAR_WIDTH'(C_PCT));
  end

endmodule

// File: rtl/numeric_attr_parser.sv
// numeric_attr_parser
// Parses a decimal or '#'-prefixed hexadecimal HTML attribute value, one
// character per cycle, into a saturating VALUE_WIDTH result.
// Optional '%' suffix support is built when NUMERIC_PARSER_PERCENT_EN is defined.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   start                 : pulse; begins a new parse (clears previous result)
//   char, char_valid      : character stream from the tokenizer
//   char_ready            : character accepted when char_valid && char_ready
//   busy, done, error     : parse status (done/error held until start/reset)
//   overflow              : sticky saturation flag
//   is_hex, is_percent    : value format flags
//   term_char             : terminator that ended the parse
//   value                 : parsed result
module numeric_attr_parser
  import numeric_attr_parser_pkg::*;
#(
  parameter int unsigned CHAR_WIDTH  = CHAR_BITS,
  parameter int unsigned VALUE_WIDTH = 10,
  parameter int unsigned MAX_DIGITS  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CHAR_WIDTH-1:0]  char,
  input  logic                   char_valid,
  output logic                   char_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   overflow,
  output logic                   is_hex,
  output logic                   is_percent,
  output logic [CHAR_WIDTH-1:0]  term_char,
  output logic [VALUE_WIDTH-1:0] value
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 2);
  localparam int unsigned AW = VALUE_WIDTH + 4;

  state_t                 r_state, w_state;
  logic [VALUE_WIDTH-1:0] r_value, w_value;
  logic                   r_overflow, w_overflow;
  logic                   r_hex, w_hex;
  logic [CHAR_WIDTH-1:0]  r_term, w_term;
  logic [CW-1:0]          r_count, w_count;
`ifdef NUMERIC_PARSER_PERCENT_EN
  logic                   r_pct, w_pct_n;
`endif

  logic          w_is_digit, w_is_term, w_is_hash, w_is_pct;
  logic [3:0]    w_digit;
  logic          w_accept;
  logic [AW-1:0] w_ext, w_acc;
  logic [CW-1:0] w_cnt_inc;
  logic          w_sat;

  char_digit_decoder #(.CHAR_WIDTH(CHAR_WIDTH)) u_dec (
    .i_char      (char),
    .i_hex       (r_hex),
    .o_is_digit  (w_is_digit),
    .o_digit     (w_digit),
    .o_is_term   (w_is_term),
    .o_is_hash   (w_is_hash),
    .o_is_percent(w_is_pct)
  );

  always_comb begin
    char_ready = (r_state == S_FIRST) || (r_state == S_DIGITS);
`ifdef NUMERIC_PARSER_PERCENT_EN
    char_ready = char_ready || (r_state == S_SUFFIX);
`endif
  end

  assign busy      = (r_state == S_FIRST) || (r_state == S_DIGITS) || (r_state == S_SUFFIX);
  assign done      = (r_state == S_DONE);
  assign error     = (r_state == S_ERROR);
  assign overflow  = r_overflow;
  assign is_hex    = r_hex;
  assign term_char = r_term;
  assign value     = r_value;
`ifdef NUMERIC_PARSER_PERCENT_EN
  assign is_percent = r_pct;
`else
  assign is_percent = 1'b0;
`endif

  // Accumulator at VALUE_WIDTH+4 bits: all-ones * 16 + 15 still fits.
  always_comb begin
    w_ext     = {4'b0000, r_value};
    w_acc     = (r_hex ? (w_ext << 4) : ((w_ext << 3) + (w_ext << 1))) + AW'(w_digit);
    w_cnt_inc = (r_count > CW'(MAX_DIGITS)) ? r_count : r_count + 1'b1;
    w_sat     = r_overflow || (w_cnt_inc > CW'(MAX_DIGITS)) ||
                (w_acc > AW'({VALUE_WIDTH{1'b1}}));
  end

  assign w_accept = char_valid && char_ready;

  always_comb begin
    w_state    = r_state;
    w_value    = r_value;
    w_overflow = r_overflow;
    w_hex      = r_hex;
    w_term     = r_term;
    w_count    = r_count;
`ifdef NUMERIC_PARSER_PERCENT_EN
    w_pct_n    = r_pct;
`endif
    if (start) begin
      // start wins over a same-cycle accept; that character is dropped
      w_state    = S_FIRST;
      w_value    = '0;
      w_overflow = 1'b0;
      w_hex      = 1'b0;
      w_term     = '0;
      w_count    = '0;
`ifdef NUMERIC_PARSER_PERCENT_EN
      w_pct_n    = 1'b0;
`endif
    end else if (w_accept) begin
      case (r_state)
        S_FIRST: begin
          if (w_is_hash) begin
            w_hex   = 1'b1;
            w_state = S_DIGITS;
          end else if (w_is_digit) begin
            w_value    = w_sat ? '1 : w_acc[VALUE_WIDTH-1:0];
            w_overflow = w_sat;
            w_count    = w_cnt_inc;
            w_state    = S_DIGITS;
          end else begin
            w_state = S_ERROR;
          end
        end
        S_DIGITS: begin
          if (w_is_digit) begin
            w_value    = w_sat ? '1 : w_acc[VALUE_WIDTH-1:0];
            w_overflow = w_sat;
            w_count    = w_cnt_inc;
          end else if (w_is_term) begin
            if (r_count == '0) begin
              w_state = S_ERROR;
            end else begin
              w_term  = char;
              w_state = S_DONE;
            end
          end else if (w_is_pct) begin
`ifdef NUMERIC_PARSER_PERCENT_EN
            if (!r_hex && (r_count != '0)) begin
              w_pct_n = 1'b1;
              w_state = S_SUFFIX;
            end else begin
              w_state = S_ERROR;
            end
`else
            w_state = S_ERROR;
`endif
          end else begin
            w_state = S_ERROR;
          end
        end
`ifdef NUMERIC_PARSER_PERCENT_EN
        S_SUFFIX: begin
          if (w_is_term) begin
            w_term  = char;
            w_state = S_DONE;
          end else begin
            w_state = S_ERROR;
          end
        end
`endif
        default: w_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_value    <= '0;
      r_overflow <= 1'b0;
      r_hex      <= 1'b0;
      r_term     <= '0;
      r_count    <= '0;
`ifdef NUMERIC_PARSER_PERCENT_EN
      r_pct      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_value    <= w_value;
      r_overflow <= w_overflow;
      r_hex      <= w_hex;
      r_term     <= w_term;
      r_count    <= w_count;
`ifdef NUMERIC_PARSER_PERCENT_EN
      r_pct      <= w_pct_n;
`endif
    end
  end

endmodule

// File: tb/tb_numeric_attr_parser.sv
module tb_numeric_attr_parser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] char  = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready, busy, done, error, overflow, is_hex, is_percent;
  logic [7:0] term_char;
  logic [9:0] value;

  int unsigned checks = 0;
  int unsigned errors = 0;

  numeric_attr_parser #(.CHAR_WIDTH(8), .VALUE_WIDTH(10), .MAX_DIGITS(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .char      (char),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .overflow  (overflow),
    .is_hex    (is_hex),
    .is_percent(is_percent),
    .term_char (term_char),
    .value     (value)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one character and hold it until accepted (bounded).
  task automatic send(input logic [7:0] c);
    int unsigned n;
    n = 0;
    @(negedge clock);
    char = c;
    char_valid = 1'b1;
    while (!char_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=%0d expected=<20", n);
    end
    @(posedge clock);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vec"}, {22'd0, char_ready, busy, done, error, overflow, is_hex, is_percent, 3'd0},
        32'd0);
    chk({tag, "_value"}, {22'd0, value}, 32'd0);
    chk({tag, "_term"}, {24'd0, term_char}, 32'd0);
  endtask

  initial begin
    // Reset
    idle(2);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_all_zero("reset");

    // Decimal "123 "
    pulse_start();
    chk("dec_busy", {31'd0, busy}, 32'd1);
    chk("dec_ready", {31'd0, char_ready}, 32'd1);
    send("1"); send("2"); send("3");
    chk("dec_val_pre", {22'd0, value}, 32'd123);
    chk("dec_done_pre", {31'd0, done}, 32'd0);
    send(" ");
    chk("dec_done", {31'd0, done}, 32'd1);
    chk("dec_error", {31'd0, error}, 32'd0);
    chk("dec_value", {22'd0, value}, 32'd123);
    chk("dec_term", {24'd0, term_char}, 32'h20);
    chk("dec_hex", {31'd0, is_hex}, 32'd0);
    chk("dec_busy_end", {31'd0, busy}, 32'd0);
    chk("dec_ready_end", {31'd0, char_ready}, 32'd0);

    // Hex "#1F>"
    pulse_start();
    chk("hex_cleared", {22'd0, value}, 32'd0);
    send("#"); send("1"); send("F"); send(">");
    chk("hex_value", {22'd0, value}, 32'd31);
    chk("hex_flag", {31'd0, is_hex}, 32'd1);
    chk("hex_done", {31'd0, done}, 32'd1);
    chk("hex_term", {24'd0, term_char}, 32'h3E);

    // Hex lowercase "#a0/"
    pulse_start();
    send("#"); send("a"); send("0"); send("/");
    chk("hexl_value", {22'd0, value}, 32'd160);
    chk("hexl_ovf", {31'd0, overflow}, 32'd0);

    // Value saturation "2000 "
    pulse_start();
    send("2"); send("0"); send("0");
    chk("sat_pre", {22'd0, value}, 32'd200);
    chk("sat_pre_ovf", {31'd0, overflow}, 32'd0);
    send("0"); send(" ");
    chk("sat_value", {22'd0, value}, 32'd1023);
    chk("sat_ovf", {31'd0, overflow}, 32'd1);
    chk("sat_done", {31'd0, done}, 32'd1);

    // Digit count saturation "00007 "
    pulse_start();
    chk("cnt_ovf_clear", {31'd0, overflow}, 32'd0);
    send("0"); send("0"); send("0"); send("0");
    chk("cnt_pre", {22'd0, value}, 32'd0);
    send("7");
    chk("cnt_sat_value", {22'd0, value}, 32'd1023);
    send(" ");
    chk("cnt_value", {22'd0, value}, 32'd1023);
    chk("cnt_ovf", {31'd0, overflow}, 32'd1);
    chk("cnt_done", {31'd0, done}, 32'd1);

    // Hex value saturation "#fff "
    pulse_start();
    send("#"); send("f"); send("f"); send("f"); send(" ");
    chk("hexsat_value", {22'd0, value}, 32'd1023);
    chk("hexsat_ovf", {31'd0, overflow}, 32'd1);

    // Errors
    pulse_start();
    send(">");
    chk("err_term_error", {31'd0, error}, 32'd1);
    chk("err_term_done", {31'd0, done}, 32'd0);
    pulse_start();
    send("#"); send(">");
    chk("err_hash_error", {31'd0, error}, 32'd1);
    chk("err_hash_done", {31'd0, done}, 32'd0);
    pulse_start();
    send("1"); send("x");
    chk("err_x_error", {31'd0, error}, 32'd1);
    chk("err_x_ready", {31'd0, char_ready}, 32'd0);
    chk("err_x_partial", {22'd0, value}, 32'd1);
    @(negedge clock);
    char = "5";
    char_valid = 1'b1;
    idle(2);
    char_valid = 1'b0;
    chk("err_hold", {31'd0, error}, 32'd1);
    chk("err_hold_value", {22'd0, value}, 32'd1);

    // Percent suffix
    pulse_start();
    send("5"); send("0"); send("%");
`ifdef NUMERIC_PARSER_PERCENT_EN
    chk("pct_busy", {31'd0, busy}, 32'd1);
    send("\"");
    chk("pct_done", {31'd0, done}, 32'd1);
    chk("pct_value", {22'd0, value}, 32'd50);
    chk("pct_flag", {31'd0, is_percent}, 32'd1);
    chk("pct_term", {24'd0, term_char}, 32'h22);
    pulse_start();
    send("#"); send("5"); send("%");
    chk("pct_hex_error", {31'd0, error}, 32'd1);
`else
    chk("pct_error", {31'd0, error}, 32'd1);
    chk("pct_done", {31'd0, done}, 32'd0);
    chk("pct_flag", {31'd0, is_percent}, 32'd0);
`endif

    // Reset mid-parse
    pulse_start();
    send("4"); send("2");
    chk("mid_value", {22'd0, value}, 32'd42);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk_all_zero("midrst");

    // Restart mid-parse
    pulse_start();
    send("4"); send("2");
    pulse_start();
    chk("restart_clear", {22'd0, value}, 32'd0);
    send("7"); send(" ");
    chk("restart_value", {22'd0, value}, 32'd7);
    chk("restart_done", {31'd0, done}, 32'd1);
    chk("restart_ovf", {31'd0, overflow}, 32'd0);

    // start beats a same-cycle character
    @(negedge clock);
    start = 1'b1;
    char = "9";
    char_valid = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    char_valid = 1'b0;
    chk("start_prio_value", {22'd0, value}, 32'd0);
    chk("start_prio_busy", {31'd0, busy}, 32'd1);

    // Gaps between characters
    pulse_start();
    send("1"); idle(2);
    send("2"); idle(3);
    send("3"); idle(1);
    chk("gap_pre_done", {31'd0, done}, 32'd0);
    send("'");
    chk("gap_value", {22'd0, value}, 32'd123);
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_term", {24'd0, term_char}, 32'h27);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
